// File: rtl/fnn_pkg.sv
// Shared definitions for the fully-connected network datapath blocks.
// Holds the serializer state type, the default word width and a helper
// that sizes counters so a single-entry range still gets one bit.
package fnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        SHIFT   = 1'b1
    } ser_state_t;

    // Counter width able to index n items, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bus between one layer's neurons, the serializer and the next layer.
//
// Handshake: neuron_valid[i] is a single-cycle strobe meaning lane i of
// neuron_out carries a new value on that clock edge. ser_valid marks a
// word on ser_data on that edge. There is no ready/backpressure; the
// consumer must accept every word on the cycle it is presented.
// dbg_state exposes the serializer FSM state for observation.
interface layer_out_serializer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = fnn_pkg::DEFAULT_DATA_WIDTH
) ();

    logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out;
    logic [NUM_NEURONS-1:0]            neuron_valid;
    logic [DATA_WIDTH-1:0]             ser_data;
    logic                              ser_valid;
    logic                              ser_last;
    logic                              busy;
    logic                              ovf;
    fnn_pkg::ser_state_t               dbg_state;

    // Producer side: drives the neuron lanes, observes the serial stream.
    modport master (
        output neuron_out,
        output neuron_valid,
        input  ser_data,
        input  ser_valid,
        input  ser_last,
        input  busy,
        input  ovf,
        input  dbg_state
    );

    // Serializer side.
    modport slave (
        input  neuron_out,
        input  neuron_valid,
        output ser_data,
        output ser_valid,
        output ser_last,
        output busy,
        output ovf,
        output dbg_state
    );

endinterface

// File: rtl/layer_out_serializer.sv
// Collects one output word per neuron lane (in any order, over any number
// of cycles) and then streams the frame out lane 0 first, one word per
// cycle without gaps. Strobes arriving while a frame is streaming are
// dropped.
// Optional feature: define LAYER_SER_OVF_EN to get a sticky ovf flag that
// records strobes dropped during streaming; otherwise ovf is tied to 0.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    layer_out_serializer_if.slave bus
);

    localparam int              CW       = cnt_width(NUM_NEURONS);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_NEURONS - 1);
    localparam logic            ONE_LANE = (NUM_NEURONS == 1);

    ser_state_t             r_state;
    ser_state_t             w_state_next;
    logic [NUM_NEURONS-1:0] r_captured;
    logic [NUM_NEURONS-1:0] w_captured_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_inc;
    logic                   w_last_word;
    logic                   w_enter_shift;
    logic [DATA_WIDTH-1:0]  w_lane0;
    logic [DATA_WIDTH-1:0]  r_hold [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  r_ser_data;
    logic                   r_ser_valid;
    logic                   r_ser_last;

    assign w_cnt_inc     = r_cnt + CW'(1);
    assign w_last_word   = (r_cnt == LAST_IDX);
    assign w_enter_shift = (r_state == COLLECT) && (w_state_next == SHIFT);
    // Lane 0 may be captured on the very edge that completes the frame,
    // so take the incoming value rather than the stale hold register.
    assign w_lane0       = bus.neuron_valid[0] ? bus.neuron_out[DATA_WIDTH-1:0] : r_hold[0];

    // Next-state logic: complete the captured mask, leave SHIFT after the last word.
    always_comb begin
        w_state_next    = r_state;
        w_captured_next = r_captured;
        case (r_state)
            COLLECT: begin
                w_captured_next = r_captured | bus.neuron_valid;
                if (&w_captured_next) begin
                    w_state_next    = SHIFT;
                    w_captured_next = '0;
                end
            end
            SHIFT: begin
                if (w_last_word) begin
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next    = COLLECT;
                w_captured_next = '0;
            end
        endcase
    end

    // State and captured-mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_captured <= '0;
        end else begin
            r_state    <= w_state_next;
            r_captured <= w_captured_next;
        end
    end

    // Per-lane hold registers, written only while collecting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_state == COLLECT && bus.neuron_valid[i]) begin
                r_hold[i] <= bus.neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Word counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ser_data  <= '0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
        end else if (w_enter_shift) begin
            r_cnt       <= '0;
            r_ser_data  <= w_lane0;
            r_ser_valid <= 1'b1;
            r_ser_last  <= ONE_LANE;
        end else if (r_state == SHIFT) begin
            if (w_last_word) begin
                r_ser_valid <= 1'b0;
                r_ser_last  <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_inc;
                r_ser_data  <= r_hold[w_cnt_inc];
                r_ser_valid <= 1'b1;
                r_ser_last  <= (w_cnt_inc == LAST_IDX);
            end
        end
    end

`ifdef LAYER_SER_OVF_EN
    logic r_ovf;

    // Sticky flag: a strobe arrived while a frame was streaming and was dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT && (|bus.neuron_valid)) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.ser_data  = r_ser_data;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;
    assign bus.busy      = (r_state == SHIFT);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer with 4 lanes of 16 bits. A frame-level
// reference model records lane values and, once every lane has arrived,
// queues the whole frame with the cycle each word must appear on. A
// separate monitor pops and compares whenever the serial stream is valid.
module tb_layer_out_serializer;
    import fnn_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_out_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(W)) bus ();

    layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0]  cyc;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] edge_cnt = 0;
    logic        mon_en   = 1'b0;

    // Reference model state (frame level)
    logic [W-1:0] held [N];
    logic [N-1:0] cap;
    int           stream_left;
    logic         exp_busy;
    logic         exp_ovf;
    logic [W-1:0] exp_hold;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [N*W-1:0] rand_lanes();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cap         = '0;
        stream_left = 0;
        exp_busy    = 1'b0;
        exp_ovf     = 1'b0;
        exp_hold    = '0;
    endtask

    // Applies one clock edge worth of strobes to the frame-level model.
    task automatic model_edge(input logic [N-1:0] v, input logic [N*W-1:0] d);
        if (stream_left > 0) begin
            if (v != '0) begin
`ifdef LAYER_SER_OVF_EN
                exp_ovf = 1'b1;
`endif
            end
            stream_left--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) held[i] = d[i*W +: W];
            end
            cap = cap | v;
            if (cap == '1) begin
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back('{cyc: edge_cnt + 32'(k), data: held[k], last: (k == N - 1)});
                end
                cap         = '0;
                stream_left = N;
            end
        end
        exp_busy = (stream_left > 0);
    endtask

    // Drive strobes for one cycle; returns 1 time unit after the sampling edge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d);
        @(negedge clk);
        bus.neuron_valid = v;
        bus.neuron_out   = d;
        @(posedge clk);
        #1;
        model_edge(v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0, rand_lanes());
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset_mid();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_valid", 32'(bus.ser_valid), 32'(0));
        chk("rst_mid_busy",  32'(bus.busy),      32'(0));
        chk("rst_mid_last",  32'(bus.ser_last),  32'(0));
        chk("rst_mid_data",  32'(bus.ser_data),  32'(0));
        chk("rst_mid_ovf",   32'(bus.ovf),       32'(0));
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares the serial stream against the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ser_valid", 32'(bus.ser_valid), 32'(exp_busy));
            chk("busy",      32'(bus.busy),      32'(exp_busy));
            chk("ovf",       32'(bus.ovf),       32'(exp_ovf));
            if (bus.ser_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h with nothing expected at edge %0d",
                             bus.ser_data, edge_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_cycle", edge_cnt,                e.cyc);
                    chk("ser_data",   32'(bus.ser_data),       32'(e.data));
                    chk("ser_last",   32'(bus.ser_last),       32'(e.last));
                    exp_hold = e.data;
                end
            end else begin
                chk("idle_hold_data", 32'(bus.ser_data), 32'(exp_hold));
                chk("idle_last",      32'(bus.ser_last), 32'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.neuron_valid = '0;
        bus.neuron_out   = '0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.ser_valid), 32'(0));
        chk("reset_last",  32'(bus.ser_last),  32'(0));
        chk("reset_busy",  32'(bus.busy),      32'(0));
        chk("reset_data",  32'(bus.ser_data),  32'(0));
        chk("reset_ovf",   32'(bus.ovf),       32'(0));
        chk("reset_state", 32'(bus.dbg_state), 32'(COLLECT));
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic frame, all lanes at once
        idle(5);
        drive_cycle(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
        idle(6);

        // Staggered arrival, one lane per strobe
        drive_cycle(4'b0001, pack4(16'hA000, $urandom(), $urandom(), $urandom()));
        idle(1);
        drive_cycle(4'b0010, pack4($urandom(), 16'h00FF, $urandom(), $urandom()));
        drive_cycle(4'b0100, pack4($urandom(), $urandom(), 16'h8001, $urandom()));
        idle(3);
        drive_cycle(4'b1000, pack4($urandom(), $urandom(), $urandom(), 16'h7FFF));
        idle(6);

        // Overwrite of lane 2 before the frame completes
        drive_cycle(4'b0100, pack4(16'h0, 16'h0, 16'h1111, 16'h0));
        drive_cycle(4'b0001, pack4(16'h00AA, 16'h0, 16'h0, 16'h0));
        drive_cycle(4'b0100, pack4(16'h0, 16'h0, 16'h2222, 16'h0));
        drive_cycle(4'b1010, pack4(16'h0, 16'h00BB, 16'h0, 16'h00DD));
        idle(6);

        // Strobes during the second streamed word are dropped
        drive_cycle(4'hF, pack4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0));
        idle(1);
        drive_cycle(4'hF, pack4(16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC));
        idle(8);

        // Reset while the second word is on the bus
        drive_cycle(4'hF, pack4(16'h0101, 16'h0202, 16'h0303, 16'h0404));
        idle(1);
        pulse_reset_mid();
        idle(6);
        drive_cycle(4'b0001, pack4(16'h0C01, 16'h0, 16'h0, 16'h0));
        idle(3);
        drive_cycle(4'b1110, pack4(16'h0, 16'h0C02, 16'h0C03, 16'h0C04));
        idle(6);

        // Back-to-back frames: second strobe on the cycle after ser_last
        drive_cycle(4'hF, pack4(16'h1001, 16'h1002, 16'h1003, 16'h1004));
        idle(4);
        drive_cycle(4'hF, pack4(16'h2001, 16'h2002, 16'h2003, 16'h2004));
        idle(6);

        // Randomized traffic, including strobes while streaming
        for (int i = 0; i < 300; i++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
            drive_cycle(v, rand_lanes());
        end

        idle(8);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 Parameter NUM_NEURONS, default 30: neurons in the producing layer, i.e. the number of lanes.
REQ-002 Parameter DATA_WIDTH, default 16: width of one neuron output and of the serial output word.
REQ-003 Ports: clk input 1, the single clock. rst input 1, asynchronous active-high reset.
REQ-004 neuron_out input NUM_NEURONS*DATA_WIDTH: packed neuron outputs; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-005 neuron_valid input NUM_NEURONS: per-lane outvalid strobes from the neurons.
REQ-006 ser_data output DATA_WIDTH, ser_valid output 1: serial word stream that feeds the next layer's myinput/myinputValid.
REQ-007 ser_last output 1: high with the final word (lane NUM_NEURONS-1) of a frame.
REQ-008 busy output 1: high while in SHIFT state.
REQ-009 ovf output 1: sticky overflow flag (see REQ-024).

Function
REQ-010 The block shall be a two-state FSM with states COLLECT and SHIFT.
REQ-011 In COLLECT, a lane whose neuron_valid is high shall capture its neuron_out slice into its hold register and set its captured bit.
REQ-012 Lanes may arrive on different cycles; a lane re-strobed before the frame completes shall overwrite its held value.
REQ-013 When, after the current edge, all captured bits are set, the FSM shall go to SHIFT on that edge and clear the captured mask.
REQ-014 Transition timing: all lanes valid at edge t gives lane 0 on ser_data with ser_valid=1 at cycle t+1, and lane k at t+1+k.
REQ-015 In SHIFT, ser_valid shall be 1 on every cycle, with no gaps; output order is lane 0 first.
REQ-016 ser_last shall be 1 only when lane NUM_NEURONS-1 is output.
REQ-017 After the ser_last cycle, the FSM shall return to COLLECT, with ser_valid=0 on the following cycle.
REQ-018 ser_data shall be registered, and shall hold its last value when ser_valid=0.
REQ-019 The word counter shall be $clog2(NUM_NEURONS) bits wide (minimum 1), and shall reset to 0 on each entry to SHIFT.
REQ-020 Any neuron_valid bit high during SHIFT shall be ignored: hold registers are not modified and the frame in flight is not corrupted.
REQ-021 NUM_NEURONS=1 shall be legal: a one-word frame with ser_valid=ser_last=1 for one cycle.

Reset
REQ-022 On rst assertion, immediately and without a clock: state COLLECT, captured mask 0, counter 0, ser_valid 0, ser_last 0, busy 0, ser_data 0, ovf 0.
REQ-023 Reset mid-SHIFT shall abandon the frame, with no further ser_valid until a new complete frame is collected. Hold registers need no reset.

Configuration
REQ-024 With LAYER_SER_OVF_EN defined, ovf shall set on any cycle where the FSM is in SHIFT and neuron_valid is nonzero, and shall stay set until rst.
REQ-025 Without LAYER_SER_OVF_EN, ovf shall be constant 0 and no overflow logic shall be synthesized. All other behaviour is identical.

Structure
REQ-026 The shared package fnn_pkg shall hold the state enum type ser_state_t {COLLECT, SHIFT} and the default DATA_WIDTH constant.
REQ-027 No sub-module: the hold registers, FSM and counter shall live in layer_out_serializer.

Verification (bench NUM_NEURONS=4, DATA_WIDTH=16)
REQ-028 Scenario 1, basic frame: neuron_valid=4'hF at cycle 10 with lanes 0x0001,0x0002,0x0003,0x0004 -> ser_data 1,2,3,4 on cycles 11-14, ser_valid=1, ser_last only on cycle 14, busy high for cycles 11-14.
REQ-029 Scenario 2, staggered arrival: lanes 0..3 strobed individually on cycles 5, 7, 8, 12 with 0xA000,0x00FF,0x8001,0x7FFF -> first word at cycle 13, in lane order, values unchanged.
REQ-030 Scenario 3, overwrite: lane 2 strobed with 0x1111 then 0x2222 before the frame completes -> 0x2222 is emitted in the third slot.
REQ-031 Scenario 4, overflow: neuron_valid=4'hF during the second word of a SHIFT -> current frame output intact, no new frame starts. ovf=1 and sticky with the macro defined; ovf=0 without it.
REQ-032 Scenario 5, reset mid-frame: rst pulsed asynchronously between clock edges after word 1 -> ser_valid drops at once, no further words; a new full capture yields a clean 4-word frame.
REQ-033 Scenario 6, back-to-back frames: second 4'hF strobe on the cycle after ser_last -> second frame starts one cycle later, with no lost or duplicated words.
